// File: rtl/greduce_acc_pkg.sv
// Shared encodings and helpers for the greduce_acc word-stream reducer.
package greduce_acc_pkg;

  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_NOR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Per-bit identity of the fold: all-ones for AND, zero for OR/XOR/NOR.
  function automatic logic identity_bit(input mode_e m);
    return (m == MODE_AND);
  endfunction

  // NOR is folded as OR; the inversion is applied once to the final word.
  function automatic mode_e fold_mode(input mode_e m);
    return (m == MODE_NOR) ? MODE_OR : m;
  endfunction

endpackage

// File: rtl/greduce_acc_glogic_n.sv
// Combinational WIDTH-bit bitwise gate: OR, AND, XOR or NOR of a and b.
module glogic_n
  import greduce_acc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_comb begin
        case (mode_e'(mode))
          MODE_OR:  y[gi] = a[gi] | b[gi];
          MODE_AND: y[gi] = a[gi] & b[gi];
          MODE_XOR: y[gi] = a[gi] ^ b[gi];
          default:  y[gi] = ~(a[gi] | b[gi]);
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/greduce_acc.sv
// Folds a handshaked stream of len words with OR/AND/XOR/NOR and presents
// the reduced word and word count on a valid/ready result port.
module greduce_acc
  import greduce_acc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [LEN_W-1:0] out_count,
  output logic             busy
);

  state_e           state_q;
  mode_e            mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] out_y_q;
  logic [LEN_W-1:0] out_count_q;

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] fin_d;
  logic [LEN_W-1:0] cnt_d;
  logic [WIDTH-1:0] ident_d;
  mode_e            start_mode;

  assign start_mode = mode_e'(mode);
  assign ident_d    = {WIDTH{identity_bit(start_mode)}};

  glogic_n #(.WIDTH(WIDTH)) u_logic (
    .a    (acc_q),
    .b    (in_data),
    .mode (fold_mode(mode_q)),
    .y    (acc_d)
  );

  assign fin_d = (mode_q == MODE_NOR) ? ~acc_d : acc_d;
  assign cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_OR;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_y_q     <= '0;
      out_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q <= start_mode;
            len_q  <= len;
            acc_q  <= ident_d;
            cnt_q  <= '0;
            if (len == '0) begin
              // Empty operation: the result is the identity, inverted for NOR.
              out_y_q     <= (start_mode == MODE_NOR) ? ~ident_d : ident_d;
              out_count_q <= '0;
              state_q     <= DONE;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (cnt_d == len_q) begin
              out_y_q     <= fin_d;
              out_count_q <= len_q;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_y     = out_y_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_greduce_acc.sv
// Directed scoreboard bench for greduce_acc: expected results are queued at
// start and popped when the block presents its result.
module tb_greduce_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic [7:0]  out_count;
  logic        busy;

  typedef struct {
    logic [15:0] y;
    logic [7:0]  count;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  greduce_acc #(.WIDTH(16), .LEN_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_count (out_count),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue start at a falling edge; mode/len are scrambled afterwards to show
  // that the running operation uses the latched copies.
  task automatic do_start(input logic [1:0] m, input logic [7:0] l,
                          input logic [15:0] ey, input logic [7:0] ec);
    exp_t e;
    @(negedge clk);
    check("idle_before_start", {31'd0, busy}, 32'd0);
    start = 1'b1;
    mode  = m;
    len   = l;
    e.y = ey;
    e.count = ec;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    len   = l + 8'd7;
  endtask

  // Called at a falling edge; the word transfers on the following rising edge.
  task automatic send(input logic [15:0] d);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'h5A5A;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("busy_during_gap", {31'd0, busy}, 32'd1);
  endtask

  // Expects out_valid at this falling edge; holds out_ready low for hold cycles
  // with a stray start, then completes the handshake.
  task automatic get_result(input string tag, input int hold);
    exp_t e;
    int waited = 0;
    check({tag, "_latency"}, {31'd0, out_valid}, 32'd1);
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_y"}, {16'd0, out_y}, {16'd0, e.y});
    check({tag, "_count"}, {24'd0, out_count}, {24'd0, e.count});
    for (int i = 0; i < hold; i++) begin
      start = (i == 2);
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_y"}, {16'd0, out_y}, {16'd0, e.y});
      check({tag, "_hold_count"}, {24'd0, out_count}, {24'd0, e.count});
      check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    start     = (hold > 0);
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_y_kept"}, {16'd0, out_y}, {16'd0, e.y});
    $display("[TB] %s: y=%04h count=%0d", tag, out_y, out_count);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; len = 8'd0;
    in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_y", {16'd0, out_y}, 32'd0);
    check("rst_out_count", {24'd0, out_count}, 32'd0);
    reset = 1'b0;

    // OR, len 3, words back-to-back
    do_start(2'b00, 8'd3, 16'h8011, 8'd3);
    send(16'h0001); send(16'h0010); send(16'h8000);
    get_result("or3", 0);

    do_start(2'b01, 8'd2, 16'h0F0F, 8'd2);
    send(16'hFF0F); send(16'h0FFF);
    get_result("and2", 0);

    do_start(2'b10, 8'd2, 16'h0000, 8'd2);
    send(16'hAAAA); send(16'hAAAA);
    get_result("xor2", 0);

    do_start(2'b11, 8'd1, 16'hFF0F, 8'd1);
    send(16'h00F0);
    get_result("nor1", 0);

    do_start(2'b01, 8'd0, 16'hFFFF, 8'd0);
    get_result("and0", 0);

    do_start(2'b00, 8'd0, 16'h0000, 8'd0);
    get_result("or0", 0);

    do_start(2'b11, 8'd0, 16'hFFFF, 8'd0);
    get_result("nor0", 0);

    // in_valid pattern 1,0,0,1,0,1
    do_start(2'b00, 8'd3, 16'h0142, 8'd3);
    send(16'h0100); idle_cycle(); idle_cycle();
    send(16'h0002); idle_cycle();
    send(16'h0040);
    get_result("or3_gaps", 0);

    // Back-pressure in DONE with stray starts
    do_start(2'b10, 8'd3, 16'h0FF0, 8'd3);
    send(16'h0F0F); send(16'hF0F0); send(16'hF00F);
    get_result("xor3_hold", 5);

    // Reset mid-ACCUM discards the operation
    do_start(2'b00, 8'd3, 16'hFFFF, 8'd3);
    send(16'hFFFF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_y", {16'd0, out_y}, 32'd0);
    check("midrst_out_count", {24'd0, out_count}, 32'd0);
    $display("[TB] reset mid-ACCUM: busy=%0b out_y=%04h", busy, out_y);

    do_start(2'b00, 8'd1, 16'h0004, 8'd1);
    send(16'h0004);
    get_result("or1_after_rst", 0);

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/greduce_acc.md
Name: greduce_acc

Overview:
- Parametrised, clocked successor to the 16-bit bitwise gates (gor16 family).
- Accepts a stream of WIDTH-bit words over a valid/ready handshake.
- Folds the words bitwise with a selectable operation (OR, AND, XOR, NOR) over a programmed word count.
- Presents the reduced word on a valid/ready output port; used wherever a multi-word mask or flag merge is needed.

Parameters:
- WIDTH, 16: data word width in bits.
- LEN_W, 8: width of the length field and of the word counter. Max words per operation = 2^LEN_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin an operation; sampled only in IDLE.
- mode  input  2  operation select: 00 OR, 01 AND, 10 XOR, 11 NOR (OR then final invert).
- len  input  LEN_W  number of words to reduce; sampled with start.
- in_valid  input  1  in_data holds a valid word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  input word.
- out_valid  output  1  out_y and out_count hold a result.
- out_ready  input  1  consumer accepts the result.
- out_y  output  WIDTH  reduced result.
- out_count  output  LEN_W  words consumed by the finished operation.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- One clock (clk). Reset is synchronous and active-high: reset is sampled on the rising edge of clk and has priority over every other input.
- Reset values:
  - state = IDLE, accumulator = 0, word counter = 0.
  - out_y = 0, out_count = 0, out_valid = 0, in_ready = 0, busy = 0.
- States and transitions:
  - IDLE: in_ready = 0, out_valid = 0.
    - On start = 1: latch mode and len.
    - Load the accumulator with the identity value: all-ones for AND, zero for OR/XOR/NOR. Clear the counter.
    - If len = 0, go to DONE; otherwise go to ACCUM.
  - ACCUM: in_ready = 1, decoded combinationally from the state register.
    - Transfer occurs on in_valid & in_ready: accumulator <= accumulator op in_data; counter increments.
    - Cycles with in_valid = 0 change nothing.
    - On the transfer where counter+1 = latched len:
      - out_y <= final value (inverted for NOR).
      - out_count <= len.
      - Next state DONE.
  - DONE: out_valid = 1; out_y and out_count held stable; in_ready = 0.
    - On out_valid & out_ready: go to IDLE. out_valid drops the next cycle.
    - out_y keeps its last value until the next result is loaded.
- Latency:
  - out_valid rises the cycle after the last accepted word.
  - For len = 0, out_valid rises the cycle after start. Result is the identity: 0x0000 for OR/XOR, 0xFFFF for AND/NOR.
  - Minimum issue interval is len + 2 cycles (start, len transfers, handshake).
- start is ignored outside IDLE, including in the same cycle as the DONE handshake. A new start is accepted no earlier than the first IDLE cycle.
- mode and len changes after start have no effect on the running operation.
- Reset mid-ACCUM or mid-DONE:
  - Discard the operation and return to IDLE with all outputs at reset values on the next cycle.
  - A pending result is lost; no stale accumulator data leaks into the next operation.
- Width rules: all operations are bitwise at WIDTH bits; no carries; the counter never wraps because len ≤ 2^LEN_W - 1.

Decomposition:
- Shared header/package contents:
  - Mode encodings: MODE_OR = 2'b00, MODE_AND = 2'b01, MODE_XOR = 2'b10, MODE_NOR = 2'b11.
  - State encodings: IDLE, ACCUM, DONE.
  - Identity-value helper (all-ones for AND, zero otherwise).
- One natural sub-module: glogic_n, a combinational WIDTH-parametrised bitwise unit (a, b, mode -> y) in the existing gate family style.
  - The FSM, counter and registers stay in greduce_acc.

Test Plan:
- Reset, then start mode = OR, len = 3; words 0x0001, 0x0010, 0x8000 with in_valid held high -> out_valid one cycle after the third accept, out_y = 0x8011, out_count = 3.
- AND, len = 2: 0xFF0F, 0x0FFF -> out_y = 0x0F0F. XOR, len = 2: 0xAAAA, 0xAAAA -> 0x0000. NOR, len = 1: 0x00F0 -> 0xFF0F.
- len = 0 with AND -> out_valid the cycle after start, out_y = 0xFFFF, out_count = 0. len = 0 with OR -> out_y = 0x0000.
- in_valid toggled 1,0,0,1,0,1 during OR len = 3 (0x0100, 0x0002, 0x0040) -> only the valid cycles count; out_y = 0x0142; busy high throughout.
- Hold out_ready low for 5 cycles in DONE and pulse start there -> out_y/out_count stable, in_ready = 0, start ignored; the handshake returns to IDLE.
- OR, len = 3: assert reset after the first word (0xFFFF) -> all outputs 0 next cycle. Then OR, len = 1 with word 0x0004 -> out_y = 0x0004.
